// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the LEGv8 EX-centred hazard sequencer.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: stage operand/event inputs, stall/flush outputs.
interface ex_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             memRead_E;
  logic [REG_W-1:0] rd_E;
  logic [REG_W-1:0] rn_D;
  logic [REG_W-1:0] rm_D;
  logic             useRm_D;
  logic             PCSrc_M;
  logic             memBusy;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_M;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport master (
    output memRead_E, rd_E, rn_D, rm_D, useRm_D, PCSrc_M, memBusy,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M,
           state_o, stallCnt, flushCnt
  );

  modport slave (
    input  memRead_E, rd_E, rn_D, rm_D, useRm_D, PCSrc_M, memBusy,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M,
           state_o, stallCnt, flushCnt
  );
endinterface

// File: rtl/ex_hazard_ctrl_detect.sv
// Load-use comparator between the EX load and the ID source registers; XZR never hazards.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             memRead_E,
  input  logic [REG_W-1:0] rd_E,
  input  logic [REG_W-1:0] rn_D,
  input  logic [REG_W-1:0] rm_D,
  input  logic             useRm_D,
  output logic             lu
);
  assign lu = memRead_E && (rd_E != REG_W'(XZR)) &&
              ((rd_E == rn_D) || (useRm_D && (rd_E == rm_D)));
endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-centred pipeline sequencer: load-use bubble, taken-branch flush window, memory freeze.
// Define HAZARD_CNT_EN to build the stall/flush event counters.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input logic             clk,
  input logic             reset,
  ex_hazard_ctrl_if.slave hz
);
  localparam logic [3:0] FC = 4'(FLUSH_CYC);

  hz_state_t  state, sav_state, cur;
  logic [3:0] cnt;
  logic       lu, busy, br;
  logic       s_f, s_d, s_e, s_m, f_d, f_e, f_m;

  hazard_detect #(.REG_W(REG_W)) u_det (
    .memRead_E (hz.memRead_E),
    .rd_E      (hz.rd_E),
    .rn_D      (hz.rn_D),
    .rm_D      (hz.rm_D),
    .useRm_D   (hz.useRm_D),
    .lu        (lu)
  );

  assign busy = hz.memBusy;
  assign br   = hz.PCSrc_M;
  // While frozen the held state acts again on the first cycle memBusy is low.
  assign cur  = (state == FREEZE) ? sav_state : state;

  always_comb begin
    {s_f, s_d, s_e, s_m, f_d, f_e, f_m} = 7'b0;
    if (reset) begin
      if (busy)              {s_f, s_d, s_e, s_m} = 4'b1111;
      else if (br)           {f_d, f_e, f_m} = 3'b111;
      else if (cur == FLUSH) f_d = 1'b1;
      else if (lu)           {s_f, s_d, f_e} = 3'b111;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      sav_state <= RUN;
      cnt       <= 4'd0;
    end else if (busy) begin
      if (state != FREEZE) sav_state <= state;
      state <= FREEZE;
    end else if (br) begin
      state <= (FLUSH_CYC > 0) ? FLUSH : RUN;
      cnt   <= FC;
    end else if (cur == FLUSH) begin
      cnt   <= cnt - 4'd1;
      state <= (cnt == 4'd1) ? RUN : FLUSH;
    end else begin
      state <= RUN;
    end
  end

  assign hz.stall_F = s_f;
  assign hz.stall_D = s_d;
  assign hz.stall_E = s_e;
  assign hz.stall_M = s_m;
  assign hz.flush_D = f_d;
  assign hz.flush_E = f_e;
  assign hz.flush_M = f_m;
  assign hz.state_o = state;

`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // A load-use stall is the only case raising stall_D without stall_E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (s_d && !s_e) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (f_m)         flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stallCnt = stall_cnt_q;
  assign hz.flushCnt = flush_cnt_q;
`else
  assign hz.stallCnt = '0;
  assign hz.flushCnt = '0;
`endif
endmodule
